// File: rtl/tx_ser_pkg.sv
// Shared constants for the block serialiser: FSM encoding and width helpers.
package tx_ser_pkg;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] StIdle = 2'd0;
  localparam logic [StateW-1:0] StSend = 2'd1;
  localparam logic [StateW-1:0] StWait = 2'd2;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter holding 0..n inclusive (n a power of two).
  function automatic int unsigned lvl_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/tx_block_fifo.sv
// Block FIFO with registered empty/full flags; flush clears it in one cycle.
module tx_block_fifo
  import tx_ser_pkg::*;
#(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [BLOCK_W-1:0]        data_in,
  output logic [BLOCK_W-1:0]        head,
  output logic                      empty,
  output logic                      full,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int unsigned PtrW = idx_w(DEPTH);
  localparam int unsigned LvlW = lvl_w(DEPTH);

  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]    level_q, level_d;
  logic               empty_q, full_q;
  logic               do_push, do_pop;

  // A push against a full FIFO is dropped even when a pop frees a slot this cycle.
  assign do_push = push & ~full_q & ~flush;
  assign do_pop  = pop & ~empty_q & ~flush;

  assign head  = mem_q[rd_ptr_q];
  assign empty = empty_q;
  assign full  = full_q;
  assign level = level_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Pointers and status flags; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == LvlW'(DEPTH));
    end
  end

endmodule

// File: rtl/tx_block_serializer.sv
// Queues wide blocks and hands them byte by byte to a UART transmitter.
module tx_block_serializer
  import tx_ser_pkg::*;
#(
  parameter int unsigned BLOCK_W   = 128,
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BLOCK_W-1:0]      block_in,
  input  logic                    write_en,
  input  logic                    flush,
  input  logic                    tx_done,
  output logic [BYTE_W-1:0]       byte_out,
  output logic                    tx_start,
  output logic                    empty,
  output logic                    full,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    overflow,
  output logic                    busy
);

  localparam int unsigned NBytes = BLOCK_W / BYTE_W;
  localparam int unsigned CntW   = idx_w(NBytes);

  if (BLOCK_W % BYTE_W != 0) begin : gen_bad_width
    $error("BLOCK_W must be an integer multiple of BYTE_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [StateW-1:0]  state_q, state_d;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               overflow_q;
  logic               fifo_pop;
  logic [BLOCK_W-1:0] fifo_head;

  tx_block_fifo #(
    .BLOCK_W (BLOCK_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (write_en),
    .pop     (fifo_pop),
    .flush   (flush),
    .data_in (block_in),
    .head    (fifo_head),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  assign tx_start = (state_q == StSend);
  assign busy     = (state_q != StIdle);
  assign overflow = overflow_q;
  assign byte_out = MSB_FIRST ? shreg_q[BLOCK_W-1 -: BYTE_W] : shreg_q[BYTE_W-1:0];

  // Serialiser next state: load from the FIFO head, send a byte, wait for done, shift.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head;
          cnt_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (tx_done) begin
          if (cnt_q == CntW'(NBytes - 1)) begin
            // Chain straight into the next block so no idle gap appears.
            if (!empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_head;
              cnt_d    = '0;
              state_d  = StSend;
            end else begin
              state_d = StIdle;
            end
          end else begin
            shreg_d = MSB_FIRST ? (shreg_q << BYTE_W) : (shreg_q >> BYTE_W);
            cnt_d   = cnt_q + CntW'(1);
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and shift register; flush aborts the block but leaves byte_out as it was.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (write_en && full && !flush) begin
      overflow_q <= 1'b1;
    end
  end

endmodule
